// File: rtl/controlador_sequenciador.sv
// ---------------------------------------------------------------------------
// controlador_sequenciador
//
// Control sequencer for the 8-bit SAP-1 datapath. A six-state one-hot ring
// counter (T1..T6) is decoded against the instruction-register opcode to
// produce every load/enable strobe on the shared bus. T1-T3 perform the
// opcode-independent fetch. T4-T6 execute LDA, ADD, SUB, OUT or HLT. Any
// other opcode behaves as a NOP.
//
// Ports:
//   CLK     in   system clock, rising edge
//   CLR     in   synchronous active-high reset (aborts current instruction)
//   opcode  in   [3:0] upper nibble of the instruction register
//   t       out  [5:0] one-hot ring state, t[0]=T1 .. t[5]=T6
//   Cp      out  program counter increment
//   Ep      out  program counter drives bus
//   Lm      out  MAR load
//   CE      out  RAM drives bus
//   Li      out  instruction register load
//   Ei      out  IR operand nibble drives bus
//   La      out  accumulator load
//   Ea      out  accumulator drives bus
//   Su      out  ALU subtract select
//   Eu      out  ALU drives bus
//   Lb      out  B register load
//   Lo      out  output register load
//   HLT     out  halted flag
// ---------------------------------------------------------------------------
module controlador_sequenciador #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] opcode,
    output logic [5:0] t,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       CE,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       HLT
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic halted;
    logic t_valid;
    logic strobes_enabled;

    // A ring value is legal only when exactly one bit is set.
    always_comb begin
        t_valid = (t != 6'd0) && ((t & (t - 6'd1)) == 6'd0);
    end

    // Strobes are suppressed during reset, while halted, and while the ring
    // holds an illegal value, so a corrupted ring can never fight on the bus.
    always_comb begin
        strobes_enabled = !CLR && !halted && t_valid;
    end

    // Ring counter and halt flag. CLR wins over everything, an illegal ring
    // self-repairs to T1, and HLT in T4 still advances to T5 on the same edge
    // it sets the halted flag, so the ring freezes at T5.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            t      <= T1;
            halted <= 1'b0;
        end else if (!t_valid) begin
            t      <= T1;
            halted <= 1'b0;
        end else if (!halted) begin
            if (t == T4 && opcode == OP_HLT) begin
                halted <= 1'b1;
            end
            t <= {t[4:0], t[5]};
        end
    end

    assign HLT = halted;

    // Strobe decode: fetch states ignore the opcode, execute states decode it.
    always_comb begin
        Cp = 1'b0;
        Ep = 1'b0;
        Lm = 1'b0;
        CE = 1'b0;
        Li = 1'b0;
        Ei = 1'b0;
        La = 1'b0;
        Ea = 1'b0;
        Su = 1'b0;
        Eu = 1'b0;
        Lb = 1'b0;
        Lo = 1'b0;
        if (strobes_enabled) begin
            case (t)
                T1: begin
                    Ep = 1'b1;
                    Lm = 1'b1;
                end
                T2: begin
                    Cp = 1'b1;
                end
                T3: begin
                    CE = 1'b1;
                    Li = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        Ei = 1'b1;
                        Lm = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        Ea = 1'b1;
                        Lo = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        CE = 1'b1;
                        La = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        CE = 1'b1;
                        Lb = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        Eu = 1'b1;
                        La = 1'b1;
                        Su = (opcode == OP_SUB);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Only one source may ever drive the shared bus.
    bus_single_driver: assert property (@(posedge CLK) $onehot0({Ep, CE, Ei, Ea, Eu}));

endmodule

// File: doc/controlador_sequenciador.md
Name: controlador_sequenciador

Overview:
- Control-sequencer for the 8-bit SAP-1 datapath. A 6-state one-hot ring counter (T1..T6) is decoded against the 4-bit opcode from the instruction register.
- Drives every load/enable strobe on the bus: PC, MAR, RAM, IR, accumulator (La/Ea), ALU, B register and output register.
- Implements fetch (T1-T3), execute (T4-T6) and HLT.

Parameters:
- OP_LDA, 4'b0000, opcode load accumulator from memory
- OP_ADD, 4'b0001, opcode A <= A + mem
- OP_SUB, 4'b0010, opcode A <= A - mem
- OP_OUT, 4'b1110, opcode output register <= A
- OP_HLT, 4'b1111, opcode halt

Ports:
- CLK  input  1  system clock, rising edge
- CLR  input  1  reset, synchronous, active-high
- opcode  input  4  upper nibble of instruction register
- t  output  6  one-hot ring state, t[0]=T1 .. t[5]=T6
- Cp  output  1  program counter increment
- Ep  output  1  program counter drives bus
- Lm  output  1  MAR load
- CE  output  1  RAM drives bus
- Li  output  1  instruction register load
- Ei  output  1  IR operand nibble drives bus
- La  output  1  accumulator load
- Ea  output  1  accumulator drives bus
- Su  output  1  ALU subtract select
- Eu  output  1  ALU drives bus
- Lb  output  1  B register load
- Lo  output  1  output register load
- HLT  output  1  halted flag

Behaviour:
- Clocking: single clock CLK. Reset CLR is synchronous, active-high. All state changes on the CLK rising edge.
- State: ring register t plus a halted flag.
- Reset value after a CLR edge: t=6'b000001 (T1), halted=0, HLT=0.
- While CLR=1, all strobe outputs are forced 0 combinationally. t and HLT continue to show the registered values until the edge.
- Ring advance: T1->T2->...->T6->T1, one state per clock, unless halted.
- Strobes are combinational from t, opcode and halted (zero added latency). A load strobe active in Tn takes effect at the rising edge that ends Tn.
- At most one bus driver (Ep, CE, Ei, Ea, Eu) is active in any state. This is required by construction and checked by an assertion.
- Fetch, opcode-independent:
  - T1: Ep, Lm.
  - T2: Cp.
  - T3: CE, Li.
- opcode is valid from T4 (the IR loads at the end of T3). It is sampled combinationally in T4-T6 and ignored in T1-T3.
- Execute:
  - LDA: T4 Ei, Lm. T5 CE, La. T6 none.
  - ADD: T4 Ei, Lm. T5 CE, Lb. T6 Eu, La.
  - SUB: as ADD, plus Su asserted in T6 together with Eu, La.
  - OUT: T4 Ea, Lo. T5 none. T6 none.
  - HLT: in T4, no strobes. At the edge ending T4, halted<=1.
  - Any other opcode: NOP, no strobes in T4-T6.
- Halted:
  - HLT=1 and t frozen at T5 (the state after T4).
  - All strobes 0.
  - Only CLR leaves halt; the next edge goes to T1 with halted=0.
- CLR mid-instruction: the instruction is aborted. No strobe fires in the CLR cycle. Restart at T1 on the next edge.
- CLR has priority over ring advance and over halt entry in the same cycle.
- Robustness: if t is ever not one-hot (e.g. no reset after power-up), the next edge forces t=T1. Strobes stay 0 while t is invalid.

Test Plan:
- CLR=1 for 2 cycles, then 0 -> t=000001 after the first edge. Strobes 0 during CLR. Then t shows 000010, 000100, ... 100000, 000001 across successive cycles.
- Fetch check with opcode=4'b0000 -> T1: Ep=Lm=1. T2: Cp=1. T3: CE=Li=1. All other strobes 0 in each state.
- opcode=OP_ADD -> T4: Ei,Lm. T5: CE,Lb. T6: Eu,La with Su=0. With OP_SUB -> identical except Su=1 in T6 only. Bus-driver one-hot assertion never fires.
- opcode=OP_OUT -> T4: Ea=Lo=1, T5/T6 silent. opcode=4'b0111 -> T4-T6 all strobes 0 and the ring wraps to T1.
- opcode=OP_HLT -> T4 silent. Next edge HLT=1, t=010000. Hold 10 cycles: t, HLT and strobes unchanged. Pulse CLR 1 cycle -> t=000001, HLT=0.
- CLR asserted during T5 of LDA -> La never asserted in that cycle. Next state T1. A following OP_LDA executes normally.
